// File: rtl/reset_seq.sv
// -----------------------------------------------------------------------------
// reset_seq
//   Staged reset sequencer for the lock subsystems. A power-on reset or a
//   debounced reset request drives all three subsystem resets high for
//   PULSE_CYC cycles. They are then released one at a time, STAGE_GAP cycles
//   apart, in the order keypad, display, lock core. After that the sequencer
//   waits up to TIMEOUT_CYC cycles for the lock core to report ready.
//
// Parameters
//   PULSE_CYC   : cycles all resets are held high (>= 1)
//   STAGE_GAP   : cycles between successive staged releases (>= 1)
//   TIMEOUT_CYC : maximum cycles spent waiting for core_ready (>= 1)
//
// Ports
//   clk        in   single clock, all logic on posedge
//   rst        in   power-on reset, synchronous, active-high
//   rst_db     in   debounced reset request (level), synchronous to clk
//   core_ready in   lock core finished initialisation (level)
//   rst_out    out  [0]=keypad, [1]=display, [2]=lock core, active-high
//   busy       out  high whenever the sequencer is not idle
//   done       out  one-cycle pulse when the lock core reports ready
//   err        out  sticky ready-timeout flag, cleared on entry to ASSERT
//   state_dbg  out  current FSM state encoding, for observation only
//
// All outputs are registers. They are loaded from the next-state values, so
// in any cycle they agree with the state register.
// -----------------------------------------------------------------------------
module reset_seq #(
    parameter int PULSE_CYC   = 16,
    parameter int STAGE_GAP   = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rst_db,
    input  logic       core_ready,
    output logic [2:0] rst_out,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ASSERT     = 3'd1,
        RELEASE    = 3'd2,
        WAIT_READY = 3'd3,
        WAIT_LOW   = 3'd4
    } state_t;

    // The counter must hold the longest interval measured in any state.
    localparam int MAX_A = (PULSE_CYC > 2 * STAGE_GAP) ? PULSE_CYC : 2 * STAGE_GAP;
    localparam int MAXC  = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
    localparam int CW    = $clog2(MAXC + 1);

    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] REL_LAST   = CW'(2 * STAGE_GAP - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] GAP        = CW'(STAGE_GAP);
    localparam logic [CW-1:0] CNT_MAX    = CW'(MAXC);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [CW-1:0]   cnt_inc;
    logic            rst_db_q;
    logic            req_edge;
    logic [2:0]      rst_out_nxt;
    logic            busy_nxt;
    logic            done_nxt;
    logic            err_nxt;

    assign req_edge  = rst_db & ~rst_db_q;
    // Saturating increment: the counter never wraps, even if a state lingers.
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    assign state_dbg = state;

    // core_ready is a plain level: it is sampled on every WAIT_READY cycle and
    // no acknowledge is returned; done is the only response to it.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt_inc;
        done_nxt    = 1'b0;
        err_nxt     = err;
        rst_out_nxt = 3'b000;

        case (state)
            IDLE: begin
                if (req_edge) state_nxt = ASSERT;
            end
            ASSERT: begin
                // A fresh request restarts the hold window in place.
                if (req_edge)                cnt_nxt   = '0;
                else if (cnt == PULSE_LAST)  state_nxt = RELEASE;
            end
            RELEASE: begin
                if (req_edge)              state_nxt = ASSERT;
                else if (cnt == REL_LAST)  state_nxt = WAIT_READY;
            end
            WAIT_READY: begin
                // An abort beats ready, and ready beats the timeout.
                if (req_edge) begin
                    state_nxt = ASSERT;
                end else if (core_ready) begin
                    state_nxt = WAIT_LOW;
                    done_nxt  = 1'b1;
                end else if (cnt == TO_LAST) begin
                    state_nxt = WAIT_LOW;
                    err_nxt   = 1'b1;
                end
            end
            WAIT_LOW: begin
                // Hold here while the request is still asserted so a held
                // button cannot start a second sequence.
                if (!rst_db) state_nxt = IDLE;
            end
            default: begin
                state_nxt = ASSERT;
            end
        endcase

        if (state_nxt != state) cnt_nxt = '0;
        if (state_nxt == ASSERT) err_nxt = 1'b0;

        case (state_nxt)
            ASSERT:  rst_out_nxt = 3'b111;
            // Keypad released first, display after one gap, lock core on the
            // transition into WAIT_READY.
            RELEASE: rst_out_nxt = (cnt_nxt < GAP) ? 3'b110 : 3'b100;
            default: rst_out_nxt = 3'b000;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ASSERT;
            cnt      <= '0;
            rst_db_q <= 1'b1;
            rst_out  <= 3'b111;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rst_db_q <= rst_db;
            rst_out  <= rst_out_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_reset_seq
//   Directed bench for reset_seq with default parameters. The driver applies
//   inputs on the falling edge and pushes the hand-derived output vector
//   expected after the next rising edge. A separate monitor pops one entry
//   per rising edge and compares it to the DUT outputs.
//   Vector layout: {state[2:0], rst_out[2:0], busy, done, err}
//   State codes: 0 IDLE, 1 ASSERT, 2 RELEASE, 3 WAIT_READY, 4 WAIT_LOW
// -----------------------------------------------------------------------------
module tb_reset_seq;

    localparam int W = 9;

    localparam logic [2:0] S_ID = 3'd0;
    localparam logic [2:0] S_AS = 3'd1;
    localparam logic [2:0] S_RL = 3'd2;
    localparam logic [2:0] S_WR = 3'd3;
    localparam logic [2:0] S_WL = 3'd4;

    logic       clk;
    logic       rst;
    logic       rst_db;
    logic       core_ready;
    logic [2:0] rst_out;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] state_dbg;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_got;
    string        mon_tag;

    reset_seq dut (
        .clk        (clk),
        .rst        (rst),
        .rst_db     (rst_db),
        .core_ready (core_ready),
        .rst_out    (rst_out),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic r, input logic db, input logic cr,
                        input logic [2:0] st, input logic [2:0] ro,
                        input logic b, input logic d, input logic e,
                        input string tag);
        @(negedge clk);
        rst        = r;
        rst_db     = db;
        core_ready = cr;
        exp_q.push_back({st, ro, b, d, e});
        tag_q.push_back(tag);
    endtask

    task automatic steps(input int n, input logic r, input logic db, input logic cr,
                         input logic [2:0] st, input logic [2:0] ro,
                         input logic b, input logic d, input logic e,
                         input string tag);
        for (int i = 0; i < n; i++) step(r, db, cr, st, ro, b, d, e, tag);
    endtask

    // Called right after the cycle that shows ASSERT with a zero count:
    // 15 more cycles of 111, 8 of 110, 8 of 100, then 000 in WAIT_READY.
    task automatic hold_release(input logic db, input logic cr, input string tag);
        steps(15, 1'b0, db, cr, S_AS, 3'b111, 1'b1, 1'b0, 1'b0, {tag, "_hold"});
        steps(8,  1'b0, db, cr, S_RL, 3'b110, 1'b1, 1'b0, 1'b0, {tag, "_rel110"});
        steps(8,  1'b0, db, cr, S_RL, 3'b100, 1'b1, 1'b0, 1'b0, {tag, "_rel100"});
        step(1'b0, db, cr, S_WR, 3'b000, 1'b1, 1'b0, 1'b0, {tag, "_wr0"});
    endtask

    // Ready seen in WAIT_READY, then button already low so back to IDLE.
    task automatic ready_to_idle(input string tag);
        step(1'b0, 1'b0, 1'b1, S_WL, 3'b000, 1'b1, 1'b1, 1'b0, {tag, "_done"});
        step(1'b0, 1'b0, 1'b1, S_ID, 3'b000, 1'b0, 1'b0, 1'b0, {tag, "_idle"});
        steps(2, 1'b0, 1'b0, 1'b1, S_ID, 3'b000, 1'b0, 1'b0, 1'b0, {tag, "_idle"});
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                mon_got = {state_dbg, rst_out, busy, done, err};
                n_checks++;
                if (mon_got !== mon_exp) begin
                    n_errors++;
                    $display("FAIL %s @%0t: got st=%0d rst_out=%b busy=%b done=%b err=%b, expected st=%0d rst_out=%b busy=%b done=%b err=%b",
                             mon_tag, $time,
                             mon_got[8:6], mon_got[5:3], mon_got[2], mon_got[1], mon_got[0],
                             mon_exp[8:6], mon_exp[5:3], mon_exp[2], mon_exp[1], mon_exp[0]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        rst_db     = 1'b0;
        core_ready = 1'b1;

        // Power-on: reset state, then the full sequence with no request edge.
        steps(3, 1'b1, 1'b0, 1'b1, S_AS, 3'b111, 1'b1, 1'b0, 1'b0, "reset");
        hold_release(1'b0, 1'b1, "por");
        ready_to_idle("por");

        // Single-cycle button press from IDLE.
        step(1'b0, 1'b1, 1'b1, S_AS, 3'b111, 1'b1, 1'b0, 1'b0, "btn_edge");
        hold_release(1'b0, 1'b1, "btn");
        ready_to_idle("btn");

        // Button held for 500 cycles: one sequence, then parked in WAIT_LOW.
        step(1'b0, 1'b1, 1'b1, S_AS, 3'b111, 1'b1, 1'b0, 1'b0, "held_edge");
        hold_release(1'b1, 1'b1, "held");
        step(1'b0, 1'b1, 1'b1, S_WL, 3'b000, 1'b1, 1'b1, 1'b0, "held_done");
        steps(466, 1'b0, 1'b1, 1'b1, S_WL, 3'b000, 1'b1, 1'b0, 1'b0, "held_wl");
        step(1'b0, 1'b0, 1'b1, S_ID, 3'b000, 1'b0, 1'b0, 1'b0, "held_idle");
        steps(2, 1'b0, 1'b0, 1'b1, S_ID, 3'b000, 1'b0, 1'b0, 1'b0, "held_idle");

        // A second edge in ASSERT restarts the hold count.
        step(1'b0, 1'b1, 1'b1, S_AS, 3'b111, 1'b1, 1'b0, 1'b0, "rs_edge");
        steps(4, 1'b0, 1'b0, 1'b1, S_AS, 3'b111, 1'b1, 1'b0, 1'b0, "rs_pre");
        step(1'b0, 1'b1, 1'b1, S_AS, 3'b111, 1'b1, 1'b0, 1'b0, "rs_again");
        hold_release(1'b0, 1'b1, "rs");
        ready_to_idle("rs");

        // Timeout: 64 WAIT_READY cycles without ready, err sticky into IDLE.
        step(1'b0, 1'b1, 1'b0, S_AS, 3'b111, 1'b1, 1'b0, 1'b0, "to_edge");
        hold_release(1'b0, 1'b0, "to");
        steps(63, 1'b0, 1'b0, 1'b0, S_WR, 3'b000, 1'b1, 1'b0, 1'b0, "to_wait");
        step(1'b0, 1'b0, 1'b0, S_WL, 3'b000, 1'b1, 1'b0, 1'b1, "to_err");
        step(1'b0, 1'b0, 1'b0, S_ID, 3'b000, 1'b0, 1'b0, 1'b1, "to_idle");
        steps(3, 1'b0, 1'b0, 1'b1, S_ID, 3'b000, 1'b0, 1'b0, 1'b1, "err_sticky");

        // err clears on the next entry to ASSERT.
        step(1'b0, 1'b1, 1'b1, S_AS, 3'b111, 1'b1, 1'b0, 1'b0, "err_clr");
        hold_release(1'b0, 1'b1, "post_to");
        ready_to_idle("post_to");

        // Race: ready on the 64th WAIT_READY cycle wins over the timeout.
        step(1'b0, 1'b1, 1'b0, S_AS, 3'b111, 1'b1, 1'b0, 1'b0, "race_edge");
        hold_release(1'b0, 1'b0, "race");
        steps(63, 1'b0, 1'b0, 1'b0, S_WR, 3'b000, 1'b1, 1'b0, 1'b0, "race_wait");
        ready_to_idle("race");

        // Abort in RELEASE, four cycles into the 110 stage.
        step(1'b0, 1'b1, 1'b1, S_AS, 3'b111, 1'b1, 1'b0, 1'b0, "ab_edge");
        steps(15, 1'b0, 1'b0, 1'b1, S_AS, 3'b111, 1'b1, 1'b0, 1'b0, "ab_hold");
        steps(4, 1'b0, 1'b0, 1'b1, S_RL, 3'b110, 1'b1, 1'b0, 1'b0, "ab_rel");
        step(1'b0, 1'b1, 1'b1, S_AS, 3'b111, 1'b1, 1'b0, 1'b0, "ab_restart");
        hold_release(1'b0, 1'b1, "ab");
        ready_to_idle("ab");

        // Abort in WAIT_READY.
        step(1'b0, 1'b1, 1'b0, S_AS, 3'b111, 1'b1, 1'b0, 1'b0, "abw_edge");
        hold_release(1'b0, 1'b0, "abw");
        steps(5, 1'b0, 1'b0, 1'b0, S_WR, 3'b000, 1'b1, 1'b0, 1'b0, "abw_wait");
        step(1'b0, 1'b1, 1'b0, S_AS, 3'b111, 1'b1, 1'b0, 1'b0, "abw_restart");
        hold_release(1'b0, 1'b1, "abw2");
        ready_to_idle("abw2");

        // rst mid-sequence with the button held: restart, and the held
        // button does not cause a second sequence afterwards.
        step(1'b0, 1'b1, 1'b1, S_AS, 3'b111, 1'b1, 1'b0, 1'b0, "mid_edge");
        steps(15, 1'b0, 1'b1, 1'b1, S_AS, 3'b111, 1'b1, 1'b0, 1'b0, "mid_hold");
        steps(3, 1'b0, 1'b1, 1'b1, S_RL, 3'b110, 1'b1, 1'b0, 1'b0, "mid_rel");
        step(1'b1, 1'b1, 1'b1, S_AS, 3'b111, 1'b1, 1'b0, 1'b0, "mid_rst");
        hold_release(1'b1, 1'b1, "mid");
        step(1'b0, 1'b1, 1'b1, S_WL, 3'b000, 1'b1, 1'b1, 1'b0, "mid_done");
        steps(5, 1'b0, 1'b1, 1'b1, S_WL, 3'b000, 1'b1, 1'b0, 1'b0, "mid_wl");
        step(1'b0, 1'b0, 1'b1, S_ID, 3'b000, 1'b0, 1'b0, 1'b0, "mid_idle");
        steps(2, 1'b0, 1'b0, 1'b1, S_ID, 3'b000, 1'b0, 1'b0, 1'b0, "mid_idle");

        // Let the monitor drain, then confirm nothing was left unchecked.
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d entries left in queue, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 The module SHALL have parameter PULSE_CYC, default 16: the number of cycles all reset outputs are held high (legal values ≥1).
REQ-002 The module SHALL have parameter STAGE_GAP, default 8: the number of cycles between successive staged releases (legal values ≥1).
REQ-003 The module SHALL have parameter TIMEOUT_CYC, default 64: the maximum number of WAIT_READY cycles (legal values ≥1).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-005 The module SHALL have port rst, input, 1 bit: power-on reset, synchronous, active-high.
REQ-006 The module SHALL have port rst_db, input, 1 bit: debounced reset request (level), synchronous to clk.
REQ-007 The module SHALL have port core_ready, input, 1 bit: high when the lock core has finished initialisation.
REQ-008 The module SHALL have port rst_out, output, 3 bits: subsystem resets, active-high; bit0 = keypad, bit1 = display, bit2 = lock core.
REQ-009 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 The module SHALL have port done, output, 1 bit: a one-cycle pulse on successful sequence completion.
REQ-011 The module SHALL have port err, output, 1 bit: sticky ready-timeout flag, cleared on entry to ASSERT.

Function
REQ-012 The FSM SHALL have exactly five states: IDLE, ASSERT, RELEASE, WAIT_READY, WAIT_LOW; all outputs SHALL be registered.
REQ-013 The edge detector SHALL register rst_db into rst_db_q; a request edge is rst_db=1 AND rst_db_q=0.
REQ-014 In IDLE, rst_out SHALL be 000, busy 0 and done 0; a request edge SHALL move the FSM to ASSERT, with rst_out=111 on the next cycle.
REQ-015 In ASSERT, rst_out SHALL be 111 for exactly PULSE_CYC consecutive cycles, after which the FSM SHALL enter RELEASE.
REQ-016 On the first RELEASE cycle, rst_out SHALL be 110; STAGE_GAP cycles later it SHALL be 100; STAGE_GAP cycles after that it SHALL be 000, and the FSM SHALL enter WAIT_READY on that same cycle.
REQ-017 In WAIT_READY, core_ready SHALL be sampled every cycle; if it is 1, done SHALL pulse high for one cycle on the following cycle and the FSM SHALL go to WAIT_LOW.
REQ-018 If core_ready stays 0 for TIMEOUT_CYC WAIT_READY cycles, err SHALL be set to 1 and the FSM SHALL go to WAIT_LOW; done SHALL stay 0.
REQ-019 If core_ready is 1 on the same cycle the timeout expires, the ready condition SHALL win (done pulses, err stays 0).
REQ-020 In WAIT_LOW, rst_out SHALL be 000 and the FSM SHALL return to IDLE on the first cycle with rst_db=0; a held button SHALL never retrigger a sequence.
REQ-021 A request edge in ASSERT SHALL restart the PULSE_CYC count, with rst_out remaining 111.
REQ-022 A request edge in RELEASE or WAIT_READY SHALL abort the sequence: next state ASSERT, rst_out=111 next cycle, counters cleared, err cleared.
REQ-023 The cycle counter SHALL be sized to clog2(max(PULSE_CYC, 2*STAGE_GAP, TIMEOUT_CYC)+1) bits, SHALL clear on every state change, and SHALL never wrap.
REQ-024 Once rst_out[n] is released, it SHALL stay low until the next entry to ASSERT; release order SHALL always be bit0, then bit1, then bit2.

Reset
REQ-025 While rst=1, the state SHALL be ASSERT, with rst_out=111, busy=1, done=0, err=0, counter=0, and rst_db_q=1.
REQ-026 After rst falls, a full sequence SHALL run (power-on sequencing) with no request edge required.
REQ-027 rst_db_q resetting to 1 SHALL ensure that a button already held at power-up produces no second sequence.
REQ-028 Assertion of rst mid-sequence SHALL restart from the ASSERT condition on the next cycle, regardless of state.

Verification
REQ-029 Power-on: release rst with rst_db=0 and core_ready=1 -> rst_out=111 for 16 cycles, 110 for 8, 100 for 8, then 000; done pulses once; busy falls and the FSM returns to IDLE.
REQ-030 Button press: rst_db rises for 1 cycle in IDLE -> rst_out=111 starting the next cycle; the staging is identical to REQ-029.
REQ-031 Held button: rst_db held high for 500 cycles with core_ready=1 -> exactly one sequence and one done pulse; busy=1 until rst_db falls.
REQ-032 Timeout: core_ready=0 throughout -> err=1 exactly 64 cycles after rst_out reaches 000, done never pulses, and err clears on the next ASSERT entry.
REQ-033 Abort: a new rst_db edge 4 cycles after rst_out=110 -> rst_out=111 next cycle, and a fresh 16-cycle hold follows.
REQ-034 Race: core_ready rises on the 64th WAIT_READY cycle -> done pulses and err=0.
